mem_arbiter_ctrl: RTL

- Single controller for the byte-wide RAM/IO port, shared by instruction fetch (IF) and load/store (MEM).
- Serialises word, half and byte accesses into byte cycles, with MEM taking priority over IF.
- Aborts fetches when a branch flushes the pipeline.
- Raises stall requests to the stall controller, which freezes the IF_ID, ID_EX and EX_MEM pipeline registers while an access is outstanding.

---
 rtl/mem_arbiter_ctrl_if.sv | 40 ++++
 rtl/mem_arbiter_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl_if.sv
// Signal bundle between the IF/MEM pipeline stages, the byte-wide RAM/IO port and the arbiter.
// The arbiter connects through the slave modport; the pipeline/RAM side uses master.
interface mem_arbiter_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rdy_in;
  logic              branch_flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              stall_req_if;
  logic              stall_req_mem;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              io_buffer_full;

  modport slave (
    input  rdy_in, branch_flush, if_req, if_addr, mem_req, mem_we, mem_size,
           mem_addr, mem_wdata, ram_din, io_buffer_full,
    output if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem,
           ram_dout, ram_a, ram_wr
  );

  modport master (
    output rdy_in, branch_flush, if_req, if_addr, mem_req, mem_we, mem_size,
           mem_addr, mem_wdata, ram_din, io_buffer_full,
    input  if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem,
           ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Arbiter for the byte-wide RAM/IO port: serialises IF fetches and MEM loads/stores
// into byte cycles, MEM first, with fetch abort on branch flush and IO write back-pressure.
module mem_arbiter_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_arbiter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_n, w_n_req;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       r_wdata, r_data, r_if_inst, r_mem_rdata;
  logic [31:0]       w_asm;
  logic              r_if_done, r_mem_done;
  logic              w_if_done, w_mem_done;
  logic              w_grant_if, w_grant_mem, w_fin_if, w_fin_mem;
  logic              w_io_blk, w_capture;

  // Done pulses are held back while the block is frozen and released when rdy_in returns.
  assign w_if_done  = r_if_done & bus.rdy_in;
  assign w_mem_done = r_mem_done & bus.rdy_in;

  assign w_addr    = r_base + ADDR_W'(r_cnt);
  assign w_io_blk  = (r_base[17:16] == IO_HI) & bus.io_buffer_full;
  assign w_capture = ((r_state == IF_RD) || (r_state == MEM_RD)) && (r_cnt != 3'd0);

  always_comb begin
    w_n_req = 3'd4;
    case (bus.mem_size)
      2'd0:    w_n_req = 3'd1;
      2'd1:    w_n_req = 3'd2;
      default: w_n_req = 3'd4;
    endcase
  end

  // Read data arrives one cycle behind its address, so count cnt lands in byte cnt-1.
  always_comb begin
    w_asm = r_data;
    case (r_cnt)
      3'd1:    w_asm[7:0]   = bus.ram_din;
      3'd2:    w_asm[15:8]  = bus.ram_din;
      3'd3:    w_asm[23:16] = bus.ram_din;
      3'd4:    w_asm[31:24] = bus.ram_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else if (bus.rdy_in) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant_if   = 1'b0;
    w_grant_mem  = 1'b0;
    w_fin_if     = 1'b0;
    w_fin_mem    = 1'b0;
    bus.ram_a    = '0;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = 8'h00;
    unique case (r_state)
      IDLE: begin
        // The cycle carrying a done pulse is a turnaround cycle: nobody is granted.
        if (bus.rdy_in && !w_if_done && !w_mem_done) begin
          if (bus.mem_req) begin
            w_grant_mem = 1'b1;
            w_state_nxt = bus.mem_we ? MEM_WR : MEM_RD;
            w_cnt_nxt   = 3'd0;
          end else if (bus.if_req && !bus.branch_flush) begin
            w_grant_if  = 1'b1;
            w_state_nxt = IF_RD;
            w_cnt_nxt   = 3'd0;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if (r_cnt < r_n) bus.ram_a = w_addr;
        if (bus.rdy_in) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if ((r_state == IF_RD) && bus.branch_flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
          end else if (r_cnt == r_n) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
            w_fin_if    = (r_state == IF_RD);
            w_fin_mem   = (r_state == MEM_RD);
          end
        end
      end
      MEM_WR: begin
        bus.ram_a    = w_addr;
        bus.ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        bus.ram_wr   = bus.rdy_in & ~w_io_blk;
        if (bus.rdy_in && !w_io_blk) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == r_n - 3'd1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
            w_fin_mem   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_base      <= '0;
      r_n         <= 3'd0;
      r_wdata     <= '0;
      r_data      <= '0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else if (bus.rdy_in) begin
      r_if_done  <= w_fin_if;
      r_mem_done <= w_fin_mem;
      // Assembly register is cleared per access so short loads come out zero-extended.
      if (w_grant_mem) begin
        r_base  <= bus.mem_addr;
        r_n     <= w_n_req;
        r_wdata <= bus.mem_wdata;
        r_data  <= '0;
      end else if (w_grant_if) begin
        r_base  <= bus.if_addr;
        r_n     <= 3'd4;
        r_data  <= '0;
      end else if (w_capture) begin
        r_data  <= w_asm;
      end
      if (w_fin_if) r_if_inst <= w_asm;
      if (w_fin_mem && (r_state == MEM_RD)) r_mem_rdata <= w_asm;
    end
  end

  assign bus.if_done       = w_if_done;
  assign bus.mem_done      = w_mem_done;
  assign bus.if_inst       = r_if_inst;
  assign bus.mem_rdata     = r_mem_rdata;
  assign bus.stall_req_if  = bus.if_req & ~w_if_done;
  assign bus.stall_req_mem = bus.mem_req & ~w_mem_done;
endmodule
